// File: rtl/reset_sequencer.sv
// Turns the raw board button into a clean system reset: synchronise, debounce,
// then hold sys_resetn low through power-on and for a fixed stretch after each release.
module reset_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int HOLD_CYCLES     = 64,
  parameter bit BTN_ACTIVE_HIGH = 1'b1
) (
  input  logic clk_i,
  input  logic resetn_i,
  input  logic btn_i,
  output logic sys_resetn_o,
  output logic btn_level_o,
  output logic btn_rise_o,
  output logic busy_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DebLast = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HoldMax = HW'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    POR_HOLD,
    RUN,
    BTN_HELD,
    STRETCH
  } state_e;

  logic          pinNorm;
  logic          s1_q, s2_q;
  logic [DW-1:0] debCnt_q, debCnt_d;
  logic          level_q, level_d;
  logic          rise_q;
  logic [HW-1:0] holdCnt_q, holdInc;
  state_e        state_q;
  logic          sysResetn_q;

  assign pinNorm = BTN_ACTIVE_HIGH ? btn_i : ~btn_i;

  // Any sample that agrees with the accepted level restarts the stability count.
  always_comb begin
    debCnt_d = debCnt_q;
    level_d  = level_q;
    if (s2_q == level_q) begin
      debCnt_d = '0;
    end else if (debCnt_q == DebLast) begin
      level_d  = s2_q;
      debCnt_d = '0;
    end else begin
      debCnt_d = debCnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      debCnt_q <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      s1_q     <= pinNorm;
      s2_q     <= s1_q;
      debCnt_q <= debCnt_d;
      level_q  <= level_d;
      rise_q   <= level_d & ~level_q;
    end
  end

  assign holdInc = (holdCnt_q == HoldMax) ? holdCnt_q : holdCnt_q + HW'(1);

  // A held button always wins over a completing hold count.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q     <= POR_HOLD;
      holdCnt_q   <= '0;
      sysResetn_q <= 1'b0;
    end else begin
      case (state_q)
        POR_HOLD, STRETCH: begin
          holdCnt_q <= holdInc;
          if (level_q) begin
            state_q     <= BTN_HELD;
            sysResetn_q <= 1'b0;
          end else if (holdInc == HoldMax) begin
            state_q     <= RUN;
            sysResetn_q <= 1'b1;
          end
        end
        RUN: begin
          if (level_q) begin
            state_q     <= BTN_HELD;
            sysResetn_q <= 1'b0;
          end
        end
        BTN_HELD: begin
          if (!level_q) begin
            state_q   <= STRETCH;
            holdCnt_q <= '0;
          end
        end
        default: begin
          state_q     <= POR_HOLD;
          holdCnt_q   <= '0;
          sysResetn_q <= 1'b0;
        end
      endcase
    end
  end

  assign sys_resetn_o = sysResetn_q;
  assign btn_level_o  = level_q;
  assign btn_rise_o   = rise_q;
  assign busy_o       = (state_q != RUN);

endmodule

// File: tb/tb_reset_sequencer.sv
// Drives an active-high and an active-low instance with the same logical button
// and scores both against a history-based model of the reset rules.
module tb_reset_sequencer;

  localparam int DebCycles  = 4;
  localparam int HoldCycles = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic press = 1'b0;
  logic btnHi, btnLo;
  logic sysHi, levelHi, riseHi, busyHi;
  logic sysLo, levelLo, riseLo, busyLo;

  int testCount = 0;
  int failCount = 0;

  logic [3:0] expQ[$];
  logic       histQ[$];
  logic       levelM;
  int         zeroRun;

  assign btnHi = press;
  assign btnLo = ~press;

  always #5 clk = ~clk;

  reset_sequencer #(
    .DEBOUNCE_CYCLES(DebCycles),
    .HOLD_CYCLES(HoldCycles),
    .BTN_ACTIVE_HIGH(1'b1)
  ) dutHi (
    .clk_i(clk),
    .resetn_i(resetn),
    .btn_i(btnHi),
    .sys_resetn_o(sysHi),
    .btn_level_o(levelHi),
    .btn_rise_o(riseHi),
    .busy_o(busyHi)
  );

  reset_sequencer #(
    .DEBOUNCE_CYCLES(DebCycles),
    .HOLD_CYCLES(HoldCycles),
    .BTN_ACTIVE_HIGH(1'b0)
  ) dutLo (
    .clk_i(clk),
    .resetn_i(resetn),
    .btn_i(btnLo),
    .sys_resetn_o(sysLo),
    .btn_level_o(levelLo),
    .btn_rise_o(riseLo),
    .busy_o(busyLo)
  );

  // Pre-reset samples and the level before the first edge count as released.
  task automatic resetModel();
    levelM  = 1'b0;
    zeroRun = 1;
    histQ.delete();
    repeat (DebCycles + 2) histQ.push_back(1'b0);
    expQ.delete();
  endtask

  // Level flips once DebCycles consecutive synchronised samples oppose it;
  // reset is released once the level has been low for HoldCycles+1 observations.
  initial begin
    logic prevLevel, newLevel, flip, expSys;
    resetModel();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        resetModel();
      end else begin
        prevLevel = levelM;
        if (prevLevel) zeroRun = 0;
        else if (zeroRun < 1000) zeroRun = zeroRun + 1;
        expSys = (zeroRun >= HoldCycles + 1);
        histQ.push_back(press);
        if (histQ.size() > DebCycles + 2) void'(histQ.pop_front());
        flip = 1'b1;
        for (int i = 0; i < DebCycles; i++) if (histQ[i] == prevLevel) flip = 1'b0;
        newLevel = flip ? ~prevLevel : prevLevel;
        levelM = newLevel;
        expQ.push_back({expSys, newLevel, newLevel & ~prevLevel, ~expSys});
      end
    end
  end

  task automatic checkOutput(input string name, input logic [3:0] got, input logic [3:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got {sys,level,rise,busy}=%b, expected %b", name, $time, got, exp);
    end
  endtask

  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (!resetn || expQ.size() == 0) e = 4'b0001;
      else e = expQ.pop_front();
      checkOutput("activeHigh", {sysHi, levelHi, riseHi, busyHi}, e);
      checkOutput("activeLow", {sysLo, levelLo, riseLo, busyLo}, e);
    end
  end

  task automatic applyStimulus(input logic pressVal, input int cycles);
    press = pressVal;
    repeat (cycles) @(posedge clk);
    #3;
  endtask

  task automatic pulseReset(input int cycles);
    resetn = 1'b0;
    repeat (cycles) @(posedge clk);
    #3;
    resetn = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", testCount, failCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    press  = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    resetn = 1'b1;
    applyStimulus(1'b0, 12);

    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 10);
    applyStimulus(1'b1, 4);
    applyStimulus(1'b0, 25);

    applyStimulus(1'b1, 20);
    applyStimulus(1'b0, 20);

    applyStimulus(1'b1, 20);
    applyStimulus(1'b0, 7);
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 25);

    applyStimulus(1'b1, 20);
    applyStimulus(1'b0, 9);
    pulseReset(2);
    applyStimulus(1'b0, 12);

    applyStimulus(1'b0, 3);
    pulseReset(1);
    applyStimulus(1'b1, 12);
    pulseReset(2);
    applyStimulus(1'b1, 15);
    applyStimulus(1'b0, 20);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 14) == 0) pulseReset($urandom_range(1, 3));
      applyStimulus(1'($urandom_range(0, 1)), $urandom_range(1, 20));
    end
    applyStimulus(1'b0, 30);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Generates the clean system reset for the core from the board reset button. It synchronises and debounces the raw button and stretches reset for a fixed count after power-on and after every button release. It sits directly downstream of the clock/reset generator, consuming its divided clk and timed resetn. Its sys_resetn drives the processor, memory and peripherals.

Parameters:
DEBOUNCE_CYCLES, 1000, consecutive stable clk cycles required to accept a new button level (>=1)
HOLD_CYCLES, 64, clk cycles sys_resetn stays low after power-on or button release (>=1)
BTN_ACTIVE_HIGH, 1, 1: pressed = btn high; 0: pressed = btn low

Ports:
clk  input  1  design clock (divided clock from the clock/reset generator)
resetn  input  1  asynchronous active-low reset; deassertion is synchronous to clk by construction of its source
btn  input  1  raw button pin, asynchronous, may bounce
sys_resetn  output  1  registered active-low system reset
btn_level  output  1  debounced button state, 1 = pressed (polarity normalised)
btn_rise  output  1  one-cycle pulse on debounced press
busy  output  1  1 whenever the FSM is not in RUN

Behaviour:
- resetn low (async, immediate): sync flops = inactive level, debounce counter = 0, btn_level = 0, btn_rise = 0, hold counter = 0, state = POR_HOLD, sys_resetn = 0, busy = 1.
- Normalise: p = BTN_ACTIVE_HIGH ? btn : ~btn. Pass p through a 2-flop synchroniser (s1, s2).
- Debounce counter:
  - Width $clog2(DEBOUNCE_CYCLES+1).
  - If s2 == btn_level, counter <= 0.
  - Otherwise counter increments. When counter == DEBOUNCE_CYCLES-1 and s2 still differs: btn_level <= s2, counter <= 0.
  - Net effect: btn_level follows a pin change on the (DEBOUNCE_CYCLES+2)-th rising edge after the change.
  - Any bounce back before that point restarts the count.
- btn_rise is registered. It is 1 exactly in the first cycle btn_level is 1, and 0 otherwise.
- FSM states: POR_HOLD, RUN, BTN_HELD, STRETCH.
  - POR_HOLD:
    - Hold counter increments each edge.
    - If btn_level == 1: go to BTN_HELD (priority over the count).
    - Else, on the edge where the count reaches HOLD_CYCLES: go to RUN.
  - RUN: btn_level == 1 -> BTN_HELD.
  - BTN_HELD: btn_level == 0 -> STRETCH, hold counter <= 0.
  - STRETCH:
    - btn_level == 1 -> BTN_HELD (counter abandoned).
    - Otherwise the counter increments; on the edge it reaches HOLD_CYCLES -> RUN.
- Hold counter: width $clog2(HOLD_CYCLES+1). It is cleared on every entry to POR_HOLD or STRETCH, and saturates; it never wraps.
- sys_resetn is registered from next-state: it is 1 exactly in cycles where state == RUN. Consequences:
  - It rises on the same edge the FSM enters RUN.
  - It falls on the edge the FSM leaves RUN, which is one edge after btn_level rises.
- busy = (state != RUN), combinational from the state register.
- Simultaneous events:
  - Press accepted on the same edge STRETCH completes: BTN_HELD wins, and sys_resetn stays 0.
  - A glitch shorter than DEBOUNCE_CYCLES never affects btn_level, btn_rise or sys_resetn.
- Reset mid-operation (any state): async return to the reset values above, then a full POR_HOLD sequence.

Test Plan:
1. Power-on, HOLD_CYCLES=8, DEBOUNCE_CYCLES=4, btn idle. Hold resetn low 5 cycles, then release -> sys_resetn = 0 and busy = 1 until the 8th rising edge after deassertion; then sys_resetn = 1 and busy = 0.
2. Glitch, DEBOUNCE=4, in RUN. Drive btn high for 3 cycles, then low -> btn_level stays 0, btn_rise never 1, sys_resetn stays 1.
3. Clean press, in RUN. Drive btn high for 20 cycles, then low -> btn_level = 1 on the 6th edge after the rise, with a single-cycle btn_rise. sys_resetn = 0 one edge later. After release, btn_level = 0 on the 6th edge; sys_resetn returns to 1 exactly 8 edges after STRETCH entry.
4. Re-press during STRETCH: release, then press again after 4 STRETCH cycles and hold 10 cycles -> FSM returns to BTN_HELD and sys_resetn stays 0 throughout. After the final release, a full 8-cycle stretch occurs before sys_resetn = 1.
5. Async reset in STRETCH: pull resetn low between clock edges -> sys_resetn, btn_level and btn_rise are 0 with no clock edge needed. After deassertion, a full 8-cycle POR_HOLD completes before sys_resetn = 1.
6. BTN_ACTIVE_HIGH=0: btn idles high. Drive btn low for 10 cycles -> btn_level = 1 and btn_rise pulses once; sys_resetn behaves identically to scenario 3.
